adc_multi_monitor: RTL and testbench
====================================

# adc_multi_monitor

Parametrised successor to the two-channel serial ADC controller. Drives a shared convert strobe and serial clock to `NUM_CH` simultaneous-sampling serial ADCs and captures one MSB-first word per channel per frame. It also produces per-channel power-of-two block averages and debounced per-channel over-limit flags. It sits between the ADC pins and the register/status logic, fully in the `clk` domain, with no derived clocks.

## Interface
Parameters:
- `NUM_CH`, 2: number of ADC channels / SDO lines.
- `DATA_W`, 14: ADC word width (bits per frame per channel).
- `OUT_W`, 16: output word width; must be ≥ `DATA_W`; samples are zero-extended.
- `CONV_CYCLES`, 22: `clk` cycles `adc_convert` is held high.
- `SCK_DIV`, 1: `clk` cycles per `adc_sck` phase (high and low each last `SCK_DIV`).
- `AVG_LOG2`, 2: averaging block size is 2^`AVG_LOG2` samples; 0 means pass-through.
- `FAIL_COUNT`, 2: consecutive over-limit samples needed to set a fail flag; must be ≥ 1.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: run frames continuously while high.
- `adc_sdo` in `NUM_CH`: serial data, bit i belongs to channel i.
- `limit` in `NUM_CH*OUT_W`: per-channel upper limit, channel i at `[i*OUT_W +: OUT_W]`.
- `limit_update` in 1: pulse that copies `limit` into the shadow registers.
- `status_clear` in 1: synchronous pulse that clears fail flags and debounce counters.
- `adc_convert` out 1: convert strobe (registered).
- `adc_sck` out 1: serial clock (registered).
- `busy` out 1: high whenever the FSM is not in IDLE.
- `sample_valid` out 1: one-cycle pulse when a new frame is ready.
- `sample_data` out `NUM_CH*OUT_W`: last frame, packed the same way as `limit`.
- `avg_valid` out 1: one-cycle pulse when a new block average is ready.
- `avg_data` out `NUM_CH*OUT_W`: last block average, packed.
- `limit_fail` out `NUM_CH`: sticky per-channel fail flags.
- `limit_any` out 1: OR of `limit_fail`.
- `frame_count` out 16: count of completed frames; wraps 0xFFFF→0.

## Operation
- The FSM has four states: IDLE, CONVERT, SHIFT, DONE.
  - IDLE: if `enable`=1, go to CONVERT.
  - CONVERT: `adc_convert`=1 for exactly `CONV_CYCLES` cycles, then go to SHIFT.
  - SHIFT: runs `DATA_W` bit periods. Each period is `SCK_DIV` cycles with `adc_sck`=1, then `SCK_DIV` cycles with `adc_sck`=0. `adc_sdo` is sampled on the `clk` edge that ends each high phase. The first bit captured is bit `DATA_W-1`.
  - DONE: one cycle. `sample_valid`=1, `sample_data` is updated, `frame_count` increments, then go to IDLE.
- Dropping `enable` mid-frame does not abort: the frame completes, then the FSM holds in IDLE.
- Shadow limits: loaded on any `limit_update` cycle. They take effect for compares from the next cycle; the power-on value is 0.
- Limit compare, in the cycle after `sample_valid`, per channel:
  - If sample > shadow limit (strict, unsigned), the debounce counter increments and saturates at `FAIL_COUNT`.
  - Otherwise the counter resets to 0.
  - The counter reaching `FAIL_COUNT` sets `limit_fail[i]`, which stays set until `status_clear` or `rst`.
- `status_clear` clears all flags and counters. It wins over a same-cycle set or increment.
- Averaging:
  - A per-channel accumulator of `OUT_W+AVG_LOG2` bits adds each sample.
  - On the 2^`AVG_LOG2`-th sample, `avg_data` = accumulator >> `AVG_LOG2` (truncating), `avg_valid` pulses, and the accumulator restarts from 0 with the next sample.
  - `rst` discards partial blocks; `status_clear` does not.

## Timing
- Reset values: `adc_convert`, `adc_sck`, `busy`, `sample_valid`, `avg_valid`, `limit_any` = 0; `sample_data`, `avg_data`, `limit_fail`, `frame_count`, counters, accumulators and shadow limits = 0. The FSM returns to IDLE immediately on `rst`, including mid-frame.
- Counting from the edge that samples `enable`=1 in IDLE as edge 0:
  - `adc_convert` is high during cycles 1..`CONV_CYCLES`.
  - SHIFT occupies the next `2*SCK_DIV*DATA_W` cycles.
  - DONE follows.
  - With defaults, `sample_valid` is high in cycle 51 and the frame period is 52 cycles.
- `limit_fail` updates 1 cycle after `sample_valid`. `limit_any` follows `limit_fail` combinationally.
- `avg_valid` occurs 1 cycle after the completing `sample_valid`.
- `adc_convert` and `adc_sck` are never high together. `adc_sck` is 0 outside SHIFT.

## Test plan
- Defaults, `enable`=1, ch0 shifts 0x2AAA, ch1 shifts 0x1555 -> `adc_convert` high for exactly 22 cycles, 14 `adc_sck` pulses, `sample_valid` in cycle 51, `sample_data`=0x1555_2AAA, next `sample_valid` 52 cycles later, `frame_count`=2.
- ch0 limit 0x1000 via `limit_update`, samples 0x1001, 0x1001 -> `limit_fail`=01 one cycle after the 2nd `sample_valid`, `limit_any`=1. Samples 0x1000, 0x1000 -> no fail (strict compare).
- ch0 samples 0x1001, 0x0FFF, 0x1001 -> `limit_fail` stays 0 (counter reset by the in-limit sample).
- `AVG_LOG2`=2, ch0 samples 10, 11, 12, 14 -> a single `avg_valid` after the 4th sample, ch0 `avg_data`=11.
- `status_clear` in the same cycle the 2nd over-limit compare would set the flag -> `limit_fail` stays 0, and one further over-limit sample does not set it.
- `rst` pulsed mid-SHIFT -> `adc_sck`/`adc_convert` go to 0 asynchronously and all outputs return to reset values. After release with `enable`=1, a full fresh frame is produced with `sample_valid` in cycle 51. Dropping `enable` mid-CONVERT -> that frame completes, then the FSM stays in IDLE with `busy`=0.

Source files
------------

// File: rtl/adc_multi_monitor_if.sv
// Pin and status bundle for adc_multi_monitor: the ADC pins plus the register-side controls and
// results. The master is the register/status side; the monitor core is the slave.
interface adc_multi_monitor_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned OUT_W  = 16
);
  logic                      enable;
  logic [NUM_CH-1:0]         adc_sdo;
  logic [NUM_CH*OUT_W-1:0]   limit;
  logic                      limit_update;
  logic                      status_clear;
  logic                      adc_convert;
  logic                      adc_sck;
  logic                      busy;
  logic                      sample_valid;
  logic [NUM_CH*OUT_W-1:0]   sample_data;
  logic                      avg_valid;
  logic [NUM_CH*OUT_W-1:0]   avg_data;
  logic [NUM_CH-1:0]         limit_fail;
  logic                      limit_any;
  logic [15:0]               frame_count;

  modport master (
    output enable, adc_sdo, limit, limit_update, status_clear,
    input  adc_convert, adc_sck, busy, sample_valid, sample_data, avg_valid, avg_data,
           limit_fail, limit_any, frame_count
  );

  modport slave (
    input  enable, adc_sdo, limit, limit_update, status_clear,
    output adc_convert, adc_sck, busy, sample_valid, sample_data, avg_valid, avg_data,
           limit_fail, limit_any, frame_count
  );
endinterface

// File: rtl/adc_multi_monitor.sv
// Multi-channel simultaneous-sampling serial ADC controller with power-of-two block averaging
// and debounced, sticky per-channel over-limit flags.
module adc_multi_monitor #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DATA_W      = 14,
  parameter int unsigned OUT_W       = 16,
  parameter int unsigned CONV_CYCLES = 22,
  parameter int unsigned SCK_DIV     = 1,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned FAIL_COUNT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  adc_multi_monitor_if.slave bus
);
  localparam int unsigned CntMax = (CONV_CYCLES > SCK_DIV) ? CONV_CYCLES : SCK_DIV;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned BitW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned DbW    = $clog2(FAIL_COUNT + 1);
  localparam int unsigned AccW   = OUT_W + AVG_LOG2;
  localparam int unsigned BlkW   = AVG_LOG2 + 1;
  localparam logic [BlkW-1:0] BlkLast = BlkW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {StIdle, StConvert, StShift, StDone} state_e;

  state_e                          state_q;
  logic [CntW-1:0]                 cnt_q;
  logic [BitW-1:0]                 bit_q;
  logic                            conv_q, sck_q, valid_q;
  logic [NUM_CH-1:0][DATA_W-1:0]   shift_q;
  logic [NUM_CH*OUT_W-1:0]         sample_q;
  logic [15:0]                     frame_q;

  logic [NUM_CH*OUT_W-1:0]         shadow_q;
  logic [NUM_CH-1:0][DbW-1:0]      db_q, db_d;
  logic [NUM_CH-1:0]               fail_q, fail_d;
  logic [NUM_CH-1:0][AccW-1:0]     acc_q, acc_d;
  logic [NUM_CH*OUT_W-1:0]         avg_q, avg_d;
  logic [BlkW-1:0]                 blk_q, blk_d;
  logic                            avg_valid_q, avg_valid_d;
  logic [OUT_W-1:0]                smp;
  logic [AccW-1:0]                 sum;

  // Frame sequencer; adc_sdo is captured on the edge that ends each sck high phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      conv_q   <= 1'b0;
      sck_q    <= 1'b0;
      valid_q  <= 1'b0;
      shift_q  <= '0;
      sample_q <= '0;
      frame_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.enable) begin
            state_q <= StConvert;
            conv_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        StConvert: begin
          if (cnt_q == CntW'(CONV_CYCLES - 1)) begin
            state_q <= StShift;
            conv_q  <= 1'b0;
            sck_q   <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StShift: begin
          if (cnt_q != CntW'(SCK_DIV - 1)) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            if (sck_q) begin
              sck_q <= 1'b0;
              for (int i = 0; i < NUM_CH; i++) begin
                shift_q[i] <= {shift_q[i][DATA_W-2:0], bus.adc_sdo[i]};
              end
            end else if (bit_q == BitW'(DATA_W - 1)) begin
              state_q <= StDone;
              valid_q <= 1'b1;
              frame_q <= frame_q + 16'd1;
              for (int i = 0; i < NUM_CH; i++) begin
                sample_q[i*OUT_W +: OUT_W] <= OUT_W'(shift_q[i]);
              end
            end else begin
              sck_q <= 1'b1;
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Compare and accumulate run on the edge that ends the sample_valid cycle.
  always_comb begin
    db_d        = db_q;
    fail_d      = fail_q;
    acc_d       = acc_q;
    avg_d       = avg_q;
    blk_d       = blk_q;
    avg_valid_d = 1'b0;
    smp         = '0;
    sum         = '0;
    if (valid_q) begin
      for (int i = 0; i < NUM_CH; i++) begin
        smp = sample_q[i*OUT_W +: OUT_W];
        if (smp > shadow_q[i*OUT_W +: OUT_W]) begin
          if (db_q[i] != DbW'(FAIL_COUNT)) db_d[i] = db_q[i] + 1'b1;
        end else begin
          db_d[i] = '0;
        end
        if (db_d[i] == DbW'(FAIL_COUNT)) fail_d[i] = 1'b1;
        sum = acc_q[i] + AccW'(smp);
        if (blk_q == BlkLast) begin
          avg_d[i*OUT_W +: OUT_W] = sum[AVG_LOG2 +: OUT_W];
          acc_d[i] = '0;
        end else begin
          acc_d[i] = sum;
        end
      end
      if (blk_q == BlkLast) begin
        blk_d       = '0;
        avg_valid_d = 1'b1;
      end else begin
        blk_d = blk_q + 1'b1;
      end
    end
    if (bus.status_clear) begin
      db_d   = '0;
      fail_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q    <= '0;
      db_q        <= '0;
      fail_q      <= '0;
      acc_q       <= '0;
      avg_q       <= '0;
      blk_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      if (bus.limit_update) shadow_q <= bus.limit;
      db_q        <= db_d;
      fail_q      <= fail_d;
      acc_q       <= acc_d;
      avg_q       <= avg_d;
      blk_q       <= blk_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  assign bus.adc_convert  = conv_q;
  assign bus.adc_sck      = sck_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.sample_valid = valid_q;
  assign bus.sample_data  = sample_q;
  assign bus.frame_count  = frame_q;
  assign bus.avg_valid    = avg_valid_q;
  assign bus.avg_data     = avg_q;
  assign bus.limit_fail   = fail_q;
  assign bus.limit_any    = |fail_q;
endmodule

// File: tb/tb_adc_multi_monitor.sv
// Bench for adc_multi_monitor: behavioural ADC pin model, directed scenarios and random frames
// checked against a frame-level reference model of the limit and averaging rules.
module tb_adc_multi_monitor;
  localparam int unsigned NUM_CH      = 2;
  localparam int unsigned DATA_W      = 14;
  localparam int unsigned OUT_W       = 16;
  localparam int unsigned CONV_CYCLES = 22;
  localparam int unsigned SCK_DIV     = 1;
  localparam int unsigned AVG_LOG2    = 2;
  localparam int unsigned FAIL_COUNT  = 2;
  localparam int unsigned BLK         = 1 << AVG_LOG2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  adc_multi_monitor_if #(.NUM_CH(NUM_CH), .OUT_W(OUT_W)) bus_if ();

  adc_multi_monitor #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .OUT_W(OUT_W), .CONV_CYCLES(CONV_CYCLES),
    .SCK_DIV(SCK_DIV), .AVG_LOG2(AVG_LOG2), .FAIL_COUNT(FAIL_COUNT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC pins: MSB presented after convert, next bit after each sck falling edge.
  logic [DATA_W-1:0] word [NUM_CH];
  int   pos = 0;
  logic sck_prev = 1'b0;
  always @(negedge clk) begin
    if (bus_if.adc_convert) pos = 0;
    else if (sck_prev && !bus_if.adc_sck) pos = pos + 1;
    sck_prev = bus_if.adc_sck;
    for (int i = 0; i < NUM_CH; i++)
      bus_if.adc_sdo[i] = (pos < int'(DATA_W)) ? word[i][DATA_W-1-pos] : 1'b0;
  end

  // Reference model state
  int unsigned             m_shadow [NUM_CH];
  int                      m_run [NUM_CH];
  logic [NUM_CH-1:0]       m_fail;
  longint unsigned         m_sum [NUM_CH];
  int                      m_n;
  logic [NUM_CH*OUT_W-1:0] m_avg;
  int unsigned             m_frames;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_shadow[i] = 0; m_run[i] = 0; m_sum[i] = 0;
    end
    m_fail = '0; m_n = 0; m_avg = '0; m_frames = 0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $display("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int unsigned at);
    at = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (bus_if.sample_valid === 1'b1) begin
        at = cyc;
        return;
      end
    end
    timeout("wait_sample_valid");
  endtask

  // Called inside the sample_valid cycle; ends one cycle later.
  task automatic check_frame(input bit clr);
    logic [NUM_CH*OUT_W-1:0] exp_s;
    bit exp_av;
    int unsigned smp;
    for (int i = 0; i < NUM_CH; i++) exp_s[i*OUT_W +: OUT_W] = OUT_W'(word[i]);
    check("sample_data", 64'(bus_if.sample_data), 64'(exp_s));
    m_frames = (m_frames + 1) & 32'hFFFF;
    check("frame_count", 64'(bus_if.frame_count), 64'(m_frames));
    exp_av = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      smp = word[i];
      if (smp > m_shadow[i]) m_run[i] = (m_run[i] + 1 > int'(FAIL_COUNT)) ? FAIL_COUNT : m_run[i] + 1;
      else m_run[i] = 0;
      if (m_run[i] >= int'(FAIL_COUNT)) m_fail[i] = 1'b1;
      m_sum[i] += smp;
    end
    m_n++;
    if (m_n == int'(BLK)) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_avg[i*OUT_W +: OUT_W] = OUT_W'(m_sum[i] / BLK);
        m_sum[i] = 0;
      end
      m_n = 0;
      exp_av = 1'b1;
    end
    if (clr) begin
      bus_if.status_clear = 1'b1;
      for (int i = 0; i < NUM_CH; i++) m_run[i] = 0;
      m_fail = '0;
    end
    tick();
    bus_if.status_clear = 1'b0;
    check("sample_valid_pulse", 64'(bus_if.sample_valid), 64'(0));
    check("limit_fail", 64'(bus_if.limit_fail), 64'(m_fail));
    check("limit_any", 64'(bus_if.limit_any), 64'(|m_fail));
    check("avg_valid", 64'(bus_if.avg_valid), 64'(exp_av));
    check("avg_data", 64'(bus_if.avg_data), 64'(m_avg));
  endtask

  task automatic run_frame(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                           input bit clr);
    int unsigned at;
    word[0] = w0;
    word[1] = w1;
    wait_valid(at);
    check_frame(clr);
  endtask

  // Next posedge is edge 0; returns timing observed up to the sample_valid cycle.
  task automatic measure_frame(output int conv_n, output int sck_n, output int vcyc,
                               output int overlap);
    logic prev;
    conv_n = 0; sck_n = 0; vcyc = -1; overlap = 0; prev = 1'b0;
    bus_if.enable = 1'b1;
    for (int c = 1; c < 200; c++) begin
      tick();
      if (bus_if.adc_convert) conv_n++;
      if (bus_if.adc_sck && !prev) sck_n++;
      if (bus_if.adc_sck && bus_if.adc_convert) overlap++;
      prev = bus_if.adc_sck;
      if (bus_if.sample_valid === 1'b1) begin
        vcyc = c;
        return;
      end
    end
  endtask

  task automatic set_limits(input int unsigned l0, input int unsigned l1);
    bus_if.limit = {OUT_W'(l1), OUT_W'(l0)};
    bus_if.limit_update = 1'b1;
    tick();
    bus_if.limit_update = 1'b0;
    m_shadow[0] = l0;
    m_shadow[1] = l1;
  endtask

  task automatic pulse_clear();
    bus_if.status_clear = 1'b1;
    tick();
    bus_if.status_clear = 1'b0;
    for (int i = 0; i < NUM_CH; i++) m_run[i] = 0;
    m_fail = '0;
  endtask

  function automatic logic [DATA_W-1:0] pick_ch0();
    case ($urandom_range(0, 4))
      0:       return DATA_W'(16'h0FFF);
      1:       return DATA_W'(16'h1000);
      2:       return DATA_W'(16'h1001);
      3:       return DATA_W'(16'h1002);
      default: return DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
    endcase
  endfunction

  initial begin
    int conv_n, sck_n, vcyc, overlap, cnt;
    int unsigned t1, t2;
    bus_if.enable = 1'b0;
    bus_if.limit = '0;
    bus_if.limit_update = 1'b0;
    bus_if.status_clear = 1'b0;
    word[0] = '0;
    word[1] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    tick();
    check("rst_convert", 64'(bus_if.adc_convert), 64'(0));
    check("rst_sck", 64'(bus_if.adc_sck), 64'(0));
    check("rst_busy", 64'(bus_if.busy), 64'(0));
    check("rst_valid", 64'(bus_if.sample_valid), 64'(0));
    check("rst_avg_valid", 64'(bus_if.avg_valid), 64'(0));
    check("rst_sample_data", 64'(bus_if.sample_data), 64'(0));
    check("rst_avg_data", 64'(bus_if.avg_data), 64'(0));
    check("rst_limit_fail", 64'(bus_if.limit_fail), 64'(0));
    check("rst_limit_any", 64'(bus_if.limit_any), 64'(0));
    check("rst_frame_count", 64'(bus_if.frame_count), 64'(0));

    // First frame timing and data, then back-to-back period
    word[0] = DATA_W'(16'h2AAA);
    word[1] = DATA_W'(16'h1555);
    measure_frame(conv_n, sck_n, vcyc, overlap);
    t1 = cyc;
    check("convert_cycles", 64'(conv_n), 64'(CONV_CYCLES));
    check("sck_pulses", 64'(sck_n), 64'(DATA_W));
    check("valid_cycle", 64'(vcyc), 64'(51));
    check("sck_convert_overlap", 64'(overlap), 64'(0));
    check_frame(1'b0);
    word[0] = DATA_W'(16'h2AAA);
    word[1] = DATA_W'(16'h1555);
    wait_valid(t2);
    check("frame_period", 64'(t2 - t1), 64'(52));
    check_frame(1'b0);
    check("frame_count_two", 64'(bus_if.frame_count), 64'(2));

    // Finish the partial block, then an aligned block of 10, 11, 12, 14 on ch0
    pulse_clear();
    run_frame(DATA_W'($urandom), DATA_W'($urandom), 1'b0);
    run_frame(DATA_W'($urandom), DATA_W'($urandom), 1'b0);
    run_frame(DATA_W'(10), DATA_W'(100), 1'b0);
    run_frame(DATA_W'(11), DATA_W'(200), 1'b0);
    run_frame(DATA_W'(12), DATA_W'(300), 1'b0);
    run_frame(DATA_W'(14), DATA_W'(401), 1'b0);
    check("avg_ch0_directed", 64'(bus_if.avg_data[OUT_W-1:0]), 64'(11));
    check("avg_ch1_directed", 64'(bus_if.avg_data[2*OUT_W-1:OUT_W]), 64'(250));

    // Debounce and strict compare
    set_limits(32'h1000, 32'hFFFF);
    pulse_clear();
    run_frame(DATA_W'(16'h1001), DATA_W'(0), 1'b0);
    run_frame(DATA_W'(16'h1001), DATA_W'(0), 1'b0);
    check("fail_after_two", 64'(bus_if.limit_fail), 64'(2'b01));
    check("any_after_two", 64'(bus_if.limit_any), 64'(1));
    pulse_clear();
    run_frame(DATA_W'(16'h1000), DATA_W'(0), 1'b0);
    run_frame(DATA_W'(16'h1000), DATA_W'(0), 1'b0);
    check("fail_equal_limit", 64'(bus_if.limit_fail), 64'(0));
    run_frame(DATA_W'(16'h1001), DATA_W'(0), 1'b0);
    run_frame(DATA_W'(16'h0FFF), DATA_W'(0), 1'b0);
    run_frame(DATA_W'(16'h1001), DATA_W'(0), 1'b0);
    check("fail_interrupted", 64'(bus_if.limit_fail), 64'(0));
    pulse_clear();
    run_frame(DATA_W'(16'h1001), DATA_W'(0), 1'b0);
    run_frame(DATA_W'(16'h1001), DATA_W'(0), 1'b1);
    check("fail_clear_wins", 64'(bus_if.limit_fail), 64'(0));
    run_frame(DATA_W'(16'h1001), DATA_W'(0), 1'b0);
    check("fail_after_clear", 64'(bus_if.limit_fail), 64'(0));

    // Random frames with occasional limit reloads and clears
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 3) == 0) set_limits(32'h1000, $urandom_range(0, 16'h3FFF));
      if ($urandom_range(0, 5) == 0) pulse_clear();
      run_frame(pick_ch0(), DATA_W'($urandom), $urandom_range(0, 7) == 0);
    end

    // Asynchronous reset in the middle of SHIFT
    cnt = 0;
    while (bus_if.adc_sck !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    if (cnt >= 200) timeout("wait_shift");
    #2 rst = 1'b1;
    #1;
    check("arst_convert", 64'(bus_if.adc_convert), 64'(0));
    check("arst_sck", 64'(bus_if.adc_sck), 64'(0));
    check("arst_busy", 64'(bus_if.busy), 64'(0));
    check("arst_sample_data", 64'(bus_if.sample_data), 64'(0));
    check("arst_avg_data", 64'(bus_if.avg_data), 64'(0));
    check("arst_limit_fail", 64'(bus_if.limit_fail), 64'(0));
    check("arst_limit_any", 64'(bus_if.limit_any), 64'(0));
    check("arst_frame_count", 64'(bus_if.frame_count), 64'(0));
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    measure_frame(conv_n, sck_n, vcyc, overlap);
    check("post_rst_valid_cycle", 64'(vcyc), 64'(51));
    check("post_rst_convert_cycles", 64'(conv_n), 64'(CONV_CYCLES));
    check_frame(1'b0);

    // Drop enable during CONVERT: frame completes, then idle
    cnt = 0;
    while (bus_if.adc_convert !== 1'b1 && cnt < 10) begin
      tick();
      cnt++;
    end
    if (cnt >= 10) timeout("wait_convert");
    repeat (5) tick();
    bus_if.enable = 1'b0;
    run_frame(word[0], word[1], 1'b0);
    check("idle_busy", 64'(bus_if.busy), 64'(0));
    cnt = 0;
    repeat (60) begin
      tick();
      if (bus_if.busy || bus_if.sample_valid || bus_if.adc_convert) cnt++;
    end
    check("held_idle", 64'(cnt), 64'(0));
    check("final_frame_count", 64'(bus_if.frame_count), 64'(m_frames));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
